// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush sequencer for the IF/ID and ID/EX latches,
// with saturating stall and flush statistics.
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_id_instr,
  input  logic [2:0]       id_ex_mem,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_br_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, hz;
  logic       stall_inc, flush_inc;
  logic       unused_ok;

  assign opcode    = if_id_instr[31:26];
  assign rs        = if_id_instr[25:21];
  assign rt        = if_id_instr[20:16];
  assign unused_ok = ^{if_id_instr[15:0], id_ex_mem[2], id_ex_mem[0]};

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      6'b000000, 6'b101011, 6'b000100: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'b100011: uses_rs = 1'b1;
      default: ;
    endcase
  end

  assign hz = id_ex_mem[1] && (id_ex_rt != 5'd0) &&
              ((uses_rs && (rs == id_ex_rt)) || (uses_rt && (rt == id_ex_rt)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    // A taken branch outranks any stall or flush in progress.
    if (ex_mem_br_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
          cnt_d        = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = CW'(STALL_CYCLES - 1);
            end
          end
        end
      endcase
    end

    stall_count_d = (stall_inc && (stall_count_q != {CNT_W{1'b1}})) ?
                    stall_count_q + CNT_W'(1) : stall_count_q;
    flush_count_d = (flush_inc && (flush_count_q != {CNT_W{1'b1}})) ?
                    flush_count_q + CNT_W'(1) : flush_count_q;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share one stimulus bus; each
// cycle pushes its expected outputs to a scoreboard that is popped mid-cycle.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  mem;
  logic [4:0]  rtq;
  logic        br;

  logic        pw0, iw0, fl0, bb0, pw1, iw1, fl1, bb1, pw2, iw2, fl2, bb2;
  logic [1:0]  st0, st1, st2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ADD  = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] ADD0 = 32'h00041820; // add $3,$0,$4
  localparam logic [31:0] NOP  = 32'h80000000;
  localparam logic [31:0] LW2  = 32'h8CA20000; // lw $2,0($5)
  localparam logic [31:0] SW2  = 32'hACA20000; // sw $2,0($5)
  localparam logic [31:0] BEQ  = 32'h10220000; // beq $1,$2

  always #5 clk = ~clk;

  hazard_ctrl u0 (
    .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem(mem), .id_ex_rt(rtq),
    .ex_mem_br_taken(br), .pc_write(pw0), .if_id_write(iw0), .if_id_flush(fl0),
    .id_ex_bubble(bb0), .state(st0), .stall_count(sc0), .flush_count(fc0));

  hazard_ctrl #(.STALL_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem(mem), .id_ex_rt(rtq),
    .ex_mem_br_taken(br), .pc_write(pw1), .if_id_write(iw1), .if_id_flush(fl1),
    .id_ex_bubble(bb1), .state(st1), .stall_count(sc1), .flush_count(fc1));

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .if_id_instr(instr), .id_ex_mem(mem), .id_ex_rt(rtq),
    .ex_mem_br_taken(br), .pc_write(pw2), .if_id_write(iw2), .if_id_flush(fl2),
    .id_ex_bubble(bb2), .state(st2), .stall_count(sc2), .flush_count(fc2));

  typedef struct {
    int          inst;
    logic [37:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  // Expected vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble, state, stall, flush}
  function automatic logic [37:0] ev(input logic pw, input logic iw, input logic fl,
                                     input logic bb, input logic [1:0] st,
                                     input int sc, input int fc);
    return {pw, iw, fl, bb, st, sc[15:0], fc[15:0]};
  endfunction

  function automatic logic [37:0] run_o(input int sc, input int fc);
    return ev(1, 1, 0, 0, 2'b00, sc, fc);
  endfunction

  function automatic logic [37:0] obs(input int inst);
    case (inst)
      0:       return {pw0, iw0, fl0, bb0, st0, sc0, fc0};
      1:       return {pw1, iw1, fl1, bb1, st1, sc1, fc1};
      default: return {pw2, iw2, fl2, bb2, st2, 12'd0, sc2, 12'd0, fc2};
    endcase
  endfunction

  // Drive one cycle of stimulus (just after posedge) and queue what it must produce.
  task automatic apply(input int inst, input logic r, input logic [31:0] i,
                       input logic [2:0] m, input logic [4:0] t, input logic b,
                       input logic [37:0] v, input string nm);
    exp_t e;
    rst = r; instr = i; mem = m; rtq = t; br = b;
    e.inst = inst; e.v = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [37:0] act;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) apply(0, 1, NOP, 3'b000, 5'd0, 0, ev(0, 0, 0, 1, 2'b00, 0, 0), "reset_hold");
      else       apply(0, 0, NOP, 3'b000, 5'd0, 0, run_o(0, 0), "reset_release");
      #3;
      e = sb.pop_front();
      act = obs(e.inst);
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [37:0] act;
    logic [37:0] stl;
    for (int k = 0; k < 6; k++) begin
      stl = ev(0, 0, 0, 1, 2'b00, k / 2, 0);
      case (k)
        0: apply(0, 0, ADD, 3'b010, 5'd2, 0, stl, "lu_rs_stall");
        1: apply(0, 0, ADD, 3'b000, 5'd2, 0, run_o(1, 0), "lu_rs_release");
        2: apply(0, 0, SW2, 3'b010, 5'd2, 0, stl, "lu_sw_rt_stall");
        3: apply(0, 0, NOP, 3'b000, 5'd0, 0, run_o(2, 0), "lu_sw_release");
        4: apply(0, 0, BEQ, 3'b010, 5'd2, 0, stl, "lu_beq_rt_stall");
        default: apply(0, 0, NOP, 3'b000, 5'd0, 0, run_o(3, 0), "lu_beq_release");
      endcase
      #3;
      e = sb.pop_front();
      act = obs(e.inst);
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
      next_cycle();
    end
  endtask

  task automatic test_no_stall();
    exp_t e;
    logic [37:0] act;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: apply(0, 0, ADD0, 3'b010, 5'd0, 0, run_o(3, 0), "ns_rt_zero");
        1: apply(0, 0, NOP,  3'b010, 5'd2, 0, run_o(3, 0), "ns_nop");
        2: apply(0, 0, LW2,  3'b010, 5'd2, 0, run_o(3, 0), "ns_lw_rt_unused");
        3: apply(0, 0, ADD,  3'b001, 5'd2, 0, run_o(3, 0), "ns_not_memread");
        default: apply(0, 0, NOP, 3'b000, 5'd0, 0, run_o(3, 0), "ns_idle");
      endcase
      #3;
      e = sb.pop_front();
      act = obs(e.inst);
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
      next_cycle();
    end
  endtask

  task automatic test_branch_priority();
    exp_t e;
    logic [37:0] act;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: apply(0, 0, ADD, 3'b010, 5'd2, 1, ev(1, 1, 1, 1, 2'b00, 3, 0), "br_over_hz");
        1: apply(0, 0, NOP, 3'b000, 5'd0, 0, run_o(3, 1), "br_over_hz_after");
        2: apply(0, 0, NOP, 3'b000, 5'd0, 1, ev(1, 1, 1, 1, 2'b00, 3, 1), "br_alone");
        default: apply(0, 0, NOP, 3'b000, 5'd0, 0, run_o(3, 2), "br_alone_after");
      endcase
      #3;
      e = sb.pop_front();
      act = obs(e.inst);
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
      next_cycle();
    end
  endtask

  task automatic test_multi_stall();
    exp_t e;
    logic [37:0] act;
    for (int k = 0; k < 11; k++) begin
      case (k)
        0:  apply(1, 1, NOP, 3'b000, 5'd0, 0, ev(0, 0, 0, 1, st1, sc1, fc1), "ms_reset");
        1:  apply(1, 0, ADD, 3'b010, 5'd2, 0, ev(0, 0, 0, 1, 2'b00, 0, 0), "ms_stall1");
        2:  apply(1, 0, NOP, 3'b000, 5'd0, 0, ev(0, 0, 0, 1, 2'b01, 1, 0), "ms_stall2");
        3:  apply(1, 0, NOP, 3'b000, 5'd0, 0, ev(0, 0, 0, 1, 2'b01, 2, 0), "ms_stall3");
        4:  apply(1, 0, NOP, 3'b000, 5'd0, 0, run_o(3, 0), "ms_done");
        5:  apply(1, 0, ADD, 3'b010, 5'd2, 0, ev(0, 0, 0, 1, 2'b00, 3, 0), "ms_abort_stall1");
        6:  apply(1, 0, NOP, 3'b000, 5'd0, 1, ev(1, 1, 1, 1, 2'b01, 4, 0), "ms_abort_br");
        7:  apply(1, 0, NOP, 3'b000, 5'd0, 0, run_o(4, 1), "ms_abort_run");
        8:  apply(1, 0, ADD, 3'b010, 5'd2, 0, ev(0, 0, 0, 1, 2'b00, 4, 1), "ms_rst_stall1");
        9:  apply(1, 1, NOP, 3'b000, 5'd0, 0, ev(0, 0, 0, 1, 2'b01, 5, 1), "ms_rst_mid");
        default: apply(1, 0, NOP, 3'b000, 5'd0, 0, run_o(0, 0), "ms_rst_run");
      endcase
      #3;
      e = sb.pop_front();
      act = obs(e.inst);
      if (k == 0) begin
        next_cycle();
        continue;
      end
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [37:0] act;
    int fc;
    apply(2, 1, NOP, 3'b000, 5'd0, 0, ev(0, 0, 0, 1, 2'b00, 0, 0), "bb_reset");
    #3;
    void'(sb.pop_front());
    next_cycle();
    for (int k = 0; k < 26; k++) begin
      if (k < 20) begin
        fc = (k > 15) ? 15 : k;
        apply(2, 0, NOP, 3'b000, 5'd0, 1,
              ev(1, 1, 1, 1, (k == 0) ? 2'b00 : 2'b10, 0, fc), "bb_flush");
      end else begin
        case (k)
          20: apply(2, 0, NOP, 3'b000, 5'd0, 0, ev(1, 1, 1, 1, 2'b10, 0, 15), "bb_tail");
          21: apply(2, 0, NOP, 3'b000, 5'd0, 0, run_o(0, 15), "bb_run");
          22: apply(2, 0, NOP, 3'b000, 5'd0, 1, ev(1, 1, 1, 1, 2'b00, 0, 15), "bb_single_br");
          23: apply(2, 0, NOP, 3'b000, 5'd0, 0, ev(1, 1, 1, 1, 2'b10, 0, 15), "bb_single_tail");
          24: apply(2, 0, ADD, 3'b010, 5'd2, 0, ev(0, 0, 0, 1, 2'b00, 0, 15), "bb_hz_after");
          default: apply(2, 0, NOP, 3'b000, 5'd0, 0, run_o(1, 15), "bb_final");
        endcase
      end
      #3;
      e = sb.pop_front();
      act = obs(e.inst);
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %h expected %h", e.nm, k, act, e.v);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; instr = NOP; mem = 3'b000; rtq = 5'd0; br = 1'b0;
    next_cycle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_multi_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
